// File: rtl/layer_controller.sv
// layer_controller: sequences one fully-connected layer over a bank of PAR
// parallel MAC neurons. For each group of PAR outputs it walks all N_IN inputs
// and emits accumulator clear/load/write-back strobes, input and weight
// addresses, and a lane-valid mask.
// Optional feature macro: LAYER_CTRL_BIAS_EN adds a BIAS state with a biasLd
// strobe between the last accumulate and write-back of every group.
module layer_controller #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned PAR   = 4,
  localparam int unsigned NGRP = (N_OUT + PAR - 1) / PAR,
  localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int unsigned AW   = ((NGRP * N_IN) > 1) ? $clog2(NGRP * N_IN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          accClr,
  output logic          accLd,
  output logic          biasLd,
  output logic          outLd,
  output logic          ready,
  output logic [IW-1:0]  in_sel,
  output logic [GW-1:0]  grp_sel,
  output logic [AW-1:0]  w_addr,
  output logic [PAR-1:0] lane_en
);

  // Number of valid lanes in the final group (1..PAR).
  localparam int unsigned REM = N_OUT - (NGRP - 1) * PAR;

  // Lane mask of the final group, built once at elaboration.
  function automatic logic [PAR-1:0] f_last_mask();
    logic [PAR-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PAR; i++) begin
      m[i] = (i < REM);
    end
    return m;
  endfunction

  localparam logic [PAR-1:0] LAST_MASK = f_last_mask();
  localparam logic [IW-1:0]  K_LAST    = IW'(N_IN - 1);
  localparam logic [GW-1:0]  G_LAST    = GW'(NGRP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_ACC,
`ifdef LAYER_CTRL_BIAS_EN
    S_BIAS,
`endif
    S_WB,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_k;
  logic [GW-1:0]  r_g;
  logic [AW-1:0]  r_waddr;
  logic [PAR-1:0] r_lane;
  logic           r_busy;
  logic           r_clr;
  logic           r_ld;
  logic           r_out;
  logic           r_rdy;
`ifdef LAYER_CTRL_BIAS_EN
  logic           r_bias;
`endif
  logic           w_advance;

  // Lane mask for a given group index: full except a partial last group.
  function automatic logic [PAR-1:0] f_lane(input logic [GW-1:0] g);
    return (g == G_LAST) ? LAST_MASK : {PAR{1'b1}};
  endfunction

  // Stall only freezes the sequencer outside IDLE.
  assign w_advance = (r_state == S_IDLE) || !stall;

  // Sequencer: state, counters and pre-stall strobes registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_g     <= '0;
      r_waddr <= '0;
      r_lane  <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_ld    <= 1'b0;
      r_out   <= 1'b0;
      r_rdy   <= 1'b0;
`ifdef LAYER_CTRL_BIAS_EN
      r_bias  <= 1'b0;
`endif
    end else if (w_advance) begin
      r_clr <= 1'b0;
      r_ld  <= 1'b0;
      r_out <= 1'b0;
      r_rdy <= 1'b0;
`ifdef LAYER_CTRL_BIAS_EN
      r_bias <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLR;
            r_k     <= '0;
            r_g     <= '0;
            r_waddr <= '0;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
            r_lane  <= f_lane(GW'(0));
          end
        end
        S_CLR: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_ACC;
          r_ld    <= 1'b1;
        end
        S_ACC: begin
          r_waddr <= r_waddr + AW'(1);
          if (r_k != K_LAST) begin
            r_k     <= r_k + IW'(1);
            r_state <= S_FETCH;
          end else begin
            r_k <= '0;
`ifdef LAYER_CTRL_BIAS_EN
            r_state <= S_BIAS;
            r_bias  <= 1'b1;
`else
            r_state <= S_WB;
            r_out   <= 1'b1;
`endif
          end
        end
`ifdef LAYER_CTRL_BIAS_EN
        S_BIAS: begin
          r_state <= S_WB;
          r_out   <= 1'b1;
        end
`endif
        S_WB: begin
          if (r_g != G_LAST) begin
            r_g     <= r_g + GW'(1);
            r_state <= S_CLR;
            r_clr   <= 1'b1;
            r_lane  <= f_lane(r_g + GW'(1));
          end else begin
            r_g     <= '0;
            r_waddr <= '0;
            r_lane  <= '0;
            r_state <= S_DONE;
            r_rdy   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are suppressed combinationally during a stall; addresses hold.
  assign busy    = r_busy;
  assign accClr  = r_clr & ~stall;
  assign accLd   = r_ld  & ~stall;
  assign outLd   = r_out & ~stall;
  assign ready   = r_rdy & ~stall;
`ifdef LAYER_CTRL_BIAS_EN
  assign biasLd  = r_bias & ~stall;
`else
  assign biasLd  = 1'b0;
`endif
  assign in_sel  = r_k;
  assign grp_sel = r_g;
  assign w_addr  = r_waddr;
  assign lane_en = r_lane;

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller: main instance N_IN=4/N_OUT=10/PAR=4,
// edge instance N_IN=2/N_OUT=1/PAR=1.
module tb_layer_controller;

`ifdef LAYER_CTRL_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  localparam int L = 3 * (2 * 4 + 2 + B);
  localparam int P = 2 * 4 + 2 + B;

  logic clk, rst, a_start, a_stall, b_start, b_stall;
  logic a_busy, a_clr, a_ld, a_bias, a_out, a_rdy;
  logic [1:0] a_insel, a_grp;
  logic [3:0] a_waddr, a_lane;
  logic b_busy, b_clr, b_ld, b_bias, b_out, b_rdy;
  logic [0:0] b_insel, b_grp, b_waddr, b_lane;

  layer_controller #(.N_IN(4), .N_OUT(10), .PAR(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .stall(a_stall),
    .busy(a_busy), .accClr(a_clr), .accLd(a_ld), .biasLd(a_bias),
    .outLd(a_out), .ready(a_rdy), .in_sel(a_insel), .grp_sel(a_grp),
    .w_addr(a_waddr), .lane_en(a_lane)
  );

  layer_controller #(.N_IN(2), .N_OUT(1), .PAR(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stall(b_stall),
    .busy(b_busy), .accClr(b_clr), .accLd(b_ld), .biasLd(b_bias),
    .outLd(b_out), .ready(b_rdy), .in_sel(b_insel), .grp_sel(b_grp),
    .w_addr(b_waddr), .lane_en(b_lane)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int ecnt = 0;
  int e0 = 0;
  int b_e0 = 0;

  int n_busy, n_clr, n_ld, n_bias, n_bias_ok, n_out, n_rdy, rdy_edge;
  logic prev_bias;
  logic [3:0] waddr_log [16];
  logic [3:0] lane_log [4];

  int bn_busy, bn_ld, bn_out, bn_rdy, b_rdy_edge, b_grp_nz;
  logic [0:0] b_lane_at_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  // Pulse/trace recorder for the main instance.
  always @(negedge clk) begin
    if (a_busy) n_busy++;
    if (a_clr) n_clr++;
    if (a_ld) begin
      if (n_ld < 16) waddr_log[n_ld] = a_waddr;
      n_ld++;
    end
    if (a_bias) n_bias++;
    if (a_out) begin
      if (prev_bias) n_bias_ok++;
      if (n_out < 4) lane_log[n_out] = a_lane;
      n_out++;
    end
    if (a_rdy) begin
      n_rdy++;
      rdy_edge = ecnt - e0;
    end
    prev_bias = a_bias;
  end

  // Pulse/trace recorder for the edge instance.
  always @(negedge clk) begin
    if (b_busy) bn_busy++;
    if (b_ld) bn_ld++;
    if (b_grp != 1'b0) b_grp_nz++;
    if (b_out) begin
      bn_out++;
      b_lane_at_out = b_lane;
    end
    if (b_rdy) begin
      bn_rdy++;
      b_rdy_edge = ecnt - b_e0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    n_busy = 0; n_clr = 0; n_ld = 0; n_bias = 0; n_bias_ok = 0;
    n_out = 0; n_rdy = 0; rdy_edge = -1; prev_bias = 1'b0;
    for (int i = 0; i < 16; i++) waddr_log[i] = '0;
    for (int i = 0; i < 4; i++) lane_log[i] = '0;
  endtask

  task automatic wait_a(input string tag);
    int t;
    t = 0;
    while (n_rdy == 0 && t < 300) begin
      step(1);
      t++;
    end
    chk(tag, n_rdy, 1);
  endtask

  task automatic step_to(input int edge_abs);
    int t;
    t = 0;
    while (ecnt < edge_abs && t < 300) begin
      step(1);
      t++;
    end
  endtask

  initial begin
    rst = 1'b0; a_start = 1'b0; a_stall = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    clear_a();
    bn_busy = 0; bn_ld = 0; bn_out = 0; bn_rdy = 0; b_rdy_edge = -1; b_grp_nz = 0;
    b_lane_at_out = 1'b0;
    step(2);
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_lane", a_lane, 0);
    chk("rst_waddr", a_waddr, 0);
    chk("rst_ready", a_rdy, 0);

    // Pass 1: start on the first edge with reset released.
    step(1);
    clear_a();
    rst = 1'b1; a_start = 1'b1; e0 = ecnt + 1;
    step(1);
    a_start = 1'b0;
    wait_a("p1_ready_seen");
    chk("p1_ready_edge", rdy_edge, L);
    chk("p1_busy_cycles", n_busy, L + 1);
    chk("p1_accClr", n_clr, 3);
    chk("p1_accLd", n_ld, 12);
    chk("p1_outLd", n_out, 3);
    chk("p1_biasLd", n_bias, 3 * B);
    chk("p1_bias_before_out", n_bias_ok, 3 * B);
    for (int i = 0; i < 12; i++) chk($sformatf("p1_waddr_%0d", i), waddr_log[i], i);
    chk("p1_lane_g0", lane_log[0], 4'b1111);
    chk("p1_lane_g1", lane_log[1], 4'b1111);
    chk("p1_lane_g2", lane_log[2], 4'b0011);
    @(negedge clk);
    chk("idle_busy", a_busy, 0);
    chk("idle_in_sel", a_insel, 0);
    chk("idle_grp_sel", a_grp, 0);
    chk("idle_lane", a_lane, 0);

    // Pass 2: stall three cycles on group 1 ACC with k=2.
    step(1);
    clear_a();
    a_start = 1'b1; e0 = ecnt + 1;
    step(1);
    a_start = 1'b0;
    step_to(e0 + P + 6);
    a_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_accLd_%0d", i), a_ld, 0);
      chk($sformatf("stall_in_sel_%0d", i), a_insel, 2);
      chk($sformatf("stall_waddr_%0d", i), a_waddr, 6);
      step(1);
    end
    a_stall = 1'b0;
    @(negedge clk);
    chk("unstall_accLd", a_ld, 1);
    chk("unstall_in_sel", a_insel, 2);
    wait_a("p2_ready_seen");
    chk("p2_ready_edge", rdy_edge, L + 3);
    chk("p2_accLd", n_ld, 12);

    // Pass 3: start re-asserted mid-pass and held through DONE.
    step(1);
    clear_a();
    a_start = 1'b1; e0 = ecnt + 1;
    step(1);
    a_start = 1'b0;
    step_to(e0 + 9);
    a_start = 1'b1;
    wait_a("p3_ready_seen");
    chk("p3_ready_edge", rdy_edge, L);
    chk("p3_accLd", n_ld, 12);
    @(negedge clk);
    chk("p3_idle_gap_busy", a_busy, 0);
    clear_a();
    e0 = ecnt + 1;
    step(1);
    a_start = 1'b0;
    @(negedge clk);
    chk("p4_restart_busy", a_busy, 1);
    chk("p4_restart_accClr", a_clr, 1);

    // Asynchronous reset mid-pass aborts without a ready pulse.
    step_to(e0 + 14);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_accLd", a_ld, 0);
    chk("abort_in_sel", a_insel, 0);
    chk("abort_grp_sel", a_grp, 0);
    chk("abort_waddr", a_waddr, 0);
    chk("abort_lane", a_lane, 0);
    step(2);
    chk("abort_no_ready", n_rdy, 0);
    rst = 1'b1;
    step(1);
    clear_a();
    a_start = 1'b1; e0 = ecnt + 1;
    step(1);
    a_start = 1'b0;
    @(negedge clk);
    chk("p5_first_in_sel", a_insel, 0);
    chk("p5_first_grp_sel", a_grp, 0);
    wait_a("p5_ready_seen");
    chk("p5_ready_edge", rdy_edge, L);
    chk("p5_accLd", n_ld, 12);
    chk("p5_waddr_first", waddr_log[0], 0);
    chk("p5_waddr_last", waddr_log[11], 11);

    // Edge configuration: single group of a single lane.
    step(1);
    b_start = 1'b1; b_e0 = ecnt + 1;
    step(1);
    b_start = 1'b0;
    begin
      int t;
      t = 0;
      while (bn_rdy == 0 && t < 100) begin
        step(1);
        t++;
      end
    end
    chk("b_ready_seen", bn_rdy, 1);
    chk("b_ready_edge", b_rdy_edge, 6 + B);
    chk("b_busy_cycles", bn_busy, 7 + B);
    chk("b_accLd", bn_ld, 2);
    chk("b_outLd", bn_out, 1);
    chk("b_lane_en", b_lane_at_out, 1);
    chk("b_grp_sel_zero", b_grp_nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
